// File: rtl/seq_mult_unit_pkg.sv
// Shared constants for the iterative HI/LO multiplier: FSM encodings and the
// default operand width the control unit also uses for its stall counter.
package seq_mult_unit_pkg;

    localparam int MULT_WIDTH = 32;

    localparam logic [1:0] MS_IDLE = 2'd0;
    localparam logic [1:0] MS_CALC = 2'd1;
    localparam logic [1:0] MS_SIGN = 2'd2;
    localparam logic [1:0] MS_DONE = 2'd3;

endpackage

// File: rtl/seq_mult_unit_if.sv
// Request/response bundle between the control unit and the multiplier.
interface seq_mult_unit_if
    import seq_mult_unit_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, op_a, op_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, op_a, op_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/seq_mult_unit_mult_add_step.sv
// One shift-add iteration: conditionally add the multiplicand into the upper
// half (with carry) and shift the whole accumulator right by one.
module mult_add_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0] acc_in,
    input  logic [WIDTH-1:0] mcand,
    output logic [2*WIDTH:0] acc_out
);
    logic [WIDTH:0] upper;

    // The top bit of acc_in is always zero after a shift, so the WIDTH+1 sum
    // cannot overflow.
    always_comb begin
        upper   = acc_in[2*WIDTH:WIDTH] + (acc_in[0] ? {1'b0, mcand} : '0);
        acc_out = {1'b0, upper, acc_in[WIDTH-1:1]};
    end
endmodule

// File: rtl/seq_mult_unit.sv
// Radix-2 sequential multiplier for mult/multu; result lands in HI/LO and is
// held there until the next operation completes.
module seq_mult_unit
    import seq_mult_unit_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input logic             clk,
    input logic             rst_n,
    seq_mult_unit_if.slave  bus
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH - 1);

    logic [1:0]         state;
    logic [2*WIDTH:0]   acc;
    logic [2*WIDTH:0]   acc_next;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   cnt;
    logic               neg;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod;
    logic               accept;

    mult_add_step #(.WIDTH(WIDTH)) u_step (
        .acc_in  (acc),
        .mcand   (mcand),
        .acc_out (acc_next)
    );

    // 0x80..0 negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        a_mag = bus.op_a;
        b_mag = bus.op_b;
        if (bus.is_signed && bus.op_a[WIDTH-1]) a_mag = ~bus.op_a + WIDTH'(1);
        if (bus.is_signed && bus.op_b[WIDTH-1]) b_mag = ~bus.op_b + WIDTH'(1);
        prod = neg ? (~acc[2*WIDTH-1:0] + (2*WIDTH)'(1)) : acc[2*WIDTH-1:0];
    end

    assign accept = bus.start && (state == MS_IDLE || state == MS_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= MS_IDLE;
            acc   <= '0;
            mcand <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                MS_IDLE, MS_DONE: begin
                    if (accept) begin
                        mcand <= a_mag;
                        acc   <= {{(WIDTH+1){1'b0}}, b_mag};
                        neg   <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        cnt   <= '0;
                        state <= MS_CALC;
                    end else begin
                        state <= MS_IDLE;
                    end
                end
                MS_CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + WIDTH'(1);
                    if (cnt == LAST) state <= MS_SIGN;
                end
                MS_SIGN: begin
                    {hi_q, lo_q} <= prod;
                    state        <= MS_DONE;
                end
                default: state <= MS_IDLE;
            endcase
        end
    end

    assign bus.busy = (state == MS_CALC) || (state == MS_SIGN);
    assign bus.done = (state == MS_DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
